// File: rtl/cam_fb_scaler_reader.sv
// Frame-buffer read engine: walks the camera buffer for a window of the 640x480 display,
// with 1x/2x/4x pixel/line replication and a border colour outside the window.
`timescale 1ns/1ps
module cam_fb_scaler_reader #(
   parameter int             AW           = 17,
   parameter int             DW           = 8,
   parameter int             CAM_SCREEN_X = 320,
   parameter int             CAM_SCREEN_Y = 240,
   parameter logic [DW-1:0]  BORDER_COLOR = 8'h00
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    scale,
   input  logic [9:0]    off_x,
   input  logic [8:0]    off_y,
   input  logic          frame_start,
   input  logic          line_start,
   input  logic          pix_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   output logic [DW-1:0] pix_out,
   output logic          pix_valid,
   output logic          in_window
);

   localparam int            XW    = $clog2(CAM_SCREEN_X + 1);
   localparam int            YW    = $clog2(CAM_SCREEN_Y + 1);
   localparam logic [AW-1:0] FILL  = AW'(CAM_SCREEN_X * CAM_SCREEN_Y);
   localparam logic [AW-1:0] ROW   = AW'(CAM_SCREEN_X);
   localparam logic [11:0]   SRC_W = 12'(CAM_SCREEN_X);
   localparam logic [11:0]   SRC_H = 12'(CAM_SCREEN_Y);

   typedef struct packed {
      logic          armed;
      logic [1:0]    sh;
      logic [9:0]    off_x;
      logic [8:0]    off_y;
   } cfg_t;

   typedef struct packed {
      logic [9:0]    vx;
      logic [8:0]    vy;
      logic [XW-1:0] cx;
      logic [1:0]    subx;
      logic [YW-1:0] cy;
      logic [1:0]    suby;
      logic [AW-1:0] row_base;
   } pos_t;

   cfg_t          r_cfg, w_cfg;
   pos_t          r_pos, w_pos, w_nxt;
   logic [AW-1:0] r_mem_addr, w_mem_addr;
   logic          w_line_win, w_pix_win;
   logic          r_pv_d1, r_pv_d2, r_win_d1, r_win_d2;
   logic [DW-1:0] r_pix_out;
   logic          r_pix_valid, r_in_window;

   // Window edges are 12 bits wide so off + len*S never wraps; positions past the
   // display are simply never reached.
   function automatic logic in_span(input logic [11:0] pos, input logic [11:0] lo,
                                    input logic [11:0] len, input logic [1:0] sh);
      logic [11:0] hi;
      hi = lo + (len << sh);
      return (pos >= lo) && (pos < hi);
   endfunction

   function automatic logic [1:0] sub_max(input logic [1:0] sh);
      case (sh)
         2'd0:    return 2'd0;
         2'd1:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      w_cfg      = r_cfg;
      w_pos      = r_pos;
      w_line_win = r_cfg.armed &&
                   in_span(12'(r_pos.vy), 12'(r_cfg.off_y), SRC_H, r_cfg.sh);

      // Start events are applied first; a coincident pixel sees the new line/frame.
      if (frame_start) begin
         w_cfg.armed = 1'b1;
         w_cfg.sh    = (scale == 2'd3) ? 2'd0 : scale;
         w_cfg.off_x = off_x;
         w_cfg.off_y = off_y;
         w_pos       = '0;
      end else if (line_start && r_cfg.armed) begin
         if (w_line_win) begin
            if (r_pos.suby == sub_max(r_cfg.sh)) begin
               w_pos.suby     = 2'd0;
               w_pos.cy       = r_pos.cy + YW'(1);
               w_pos.row_base = r_pos.row_base + ROW;
            end else begin
               w_pos.suby = r_pos.suby + 2'd1;
            end
         end
         if (r_pos.vy != '1)
            w_pos.vy = r_pos.vy + 9'd1;
         w_pos.vx   = '0;
         w_pos.cx   = '0;
         w_pos.subx = '0;
      end

      w_pix_win = w_cfg.armed &&
                  in_span(12'(w_pos.vx), 12'(w_cfg.off_x), SRC_W, w_cfg.sh) &&
                  in_span(12'(w_pos.vy), 12'(w_cfg.off_y), SRC_H, w_cfg.sh);

      w_nxt      = w_pos;
      w_mem_addr = r_mem_addr;
      if (pix_en) begin
         if (w_pix_win) begin
            w_mem_addr = w_pos.row_base + AW'(w_pos.cx);
            if (w_pos.subx == sub_max(w_cfg.sh)) begin
               w_nxt.subx = 2'd0;
               w_nxt.cx   = w_pos.cx + XW'(1);
            end else begin
               w_nxt.subx = w_pos.subx + 2'd1;
            end
         end else begin
            w_mem_addr = FILL;
         end
         if (w_pos.vx != '1)
            w_nxt.vx = w_pos.vx + 10'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cfg       <= '0;
         r_pos       <= '0;
         r_mem_addr  <= '0;
         r_pv_d1     <= 1'b0;
         r_pv_d2     <= 1'b0;
         r_win_d1    <= 1'b0;
         r_win_d2    <= 1'b0;
         r_pix_out   <= '0;
         r_pix_valid <= 1'b0;
         r_in_window <= 1'b0;
      end else begin
         r_cfg       <= w_cfg;
         r_pos       <= w_nxt;
         r_mem_addr  <= w_mem_addr;
         r_pv_d1     <= pix_en;
         r_win_d1    <= pix_en & w_pix_win;
         r_pv_d2     <= r_pv_d1;
         r_win_d2    <= r_win_d1;
         r_pix_valid <= r_pv_d2;
         if (r_pv_d2) begin
            r_pix_out   <= r_win_d2 ? mem_data : BORDER_COLOR;
            r_in_window <= r_win_d2;
         end
      end
   end

   assign mem_addr  = r_mem_addr;
   assign pix_out   = r_pix_out;
   assign pix_valid = r_pix_valid;
   assign in_window = r_in_window;

endmodule
